ctrl_seq_decoder: RTL and testbench
===================================

Name: ctrl_seq_decoder

Overview:
- Sits directly downstream of the controller step counter in the 64x64 vector multiplier.
- Decodes the counter's step value, its end flag and the shared start level into datapath controls: operand-memory read strobes and addresses, MAC enable aligned to memory latency, accumulator clear, result write-back, and a host done/ack handshake.
- Does not store data; it is the timing hub between the counter and the PE/memory datapath.

Parameters:
- MAT_SIZE, 64, vector length; the counter terminates at MAT_SIZE+2.
- CNT_W, 8, width of the incoming step count; all-ones means "finished".
- RD_LAT, 1, operand-memory read latency in cycles (1..4); sets MAC enable delay.
- ADDR_W, $clog2(MAT_SIZE), read-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run level, the same signal that drives the step counter.
- state_count  in  CNT_W  step count from the counter.
- end_signal  in  1  counter's sticky end flag.
- host_ack  in  1  host acknowledge of done.
- acc_clr  out  1  one-cycle accumulator clear.
- rd_en  out  1  operand-memory read strobe.
- rd_addr  out  ADDR_W  operand-memory read address.
- mac_en  out  1  PE multiply-accumulate enable, rd_en delayed by RD_LAT.
- out_we  out  1  one-cycle result write-back strobe.
- done  out  1  run complete; held until acknowledged.
- seq_err  out  1  sticky sequence error (optional feature only; otherwise tied 0).

Behaviour:
- Reset:
  - Clock is clk; reset is rst, asynchronous and active-high.
  - Every output and every pipeline stage is 0 on reset. FSM enters IDLE.
  - Reset asserted mid-run clears everything immediately, including mac_en pipeline contents.
- Output timing: all outputs are registered, one cycle after the sampled inputs that cause them.
- FSM states: IDLE, STREAM, DRAIN, WB, DONE, HALT.
- IDLE:
  - If start=1 and state_count=0: pulse acc_clr, go to STREAM.
  - Otherwise no outputs.
- STREAM:
  - If start=1 and state_count is in 1..MAT_SIZE: rd_en=1, rd_addr=state_count-1 (truncated to ADDR_W).
  - If start=0: rd_en=0, rd_addr holds. This is a stall; the counter is frozen too.
  - On sampling state_count=MAT_SIZE with start=1: go to DRAIN.
- DRAIN (state_count=MAT_SIZE+1): rd_en=0; wait for start=1 before advancing to WB.
- WB:
  - On sampling state_count=MAT_SIZE+2 with start=1: pulse out_we once.
  - Wait for end_signal.
- end_signal rising edge (end_signal=1 with previous sample 0): go to DONE, set done=1.
  - This is detected in any non-IDLE state.
- DONE:
  - done holds 1 until host_ack=1 is sampled while done=1. Then done=0 next cycle; go to HALT.
  - host_ack while done=0 is ignored, including ack in the same cycle that done rises.
- HALT:
  - All outputs 0.
  - The counter never restarts without reset, so only rst leaves HALT.
- mac_en:
  - Exact RD_LAT-cycle delayed copy of rd_en. Stalls propagate as bubbles.
  - After the last address there are exactly RD_LAT further cycles of pipeline drain, then mac_en=0.
- Pulse counts per run: exactly MAT_SIZE rd_en cycles, one acc_clr, one out_we, one done rise.

Optional Feature:
- Macro: CTRL_SEQ_CHECK_EN.
- Defined:
  - seq_err is set when, while start=1 and the FSM is not IDLE/HALT, a sampled state_count is neither the previous value nor previous+1.
  - The transition from MAT_SIZE+2 to all-ones is legal.
  - seq_err is sticky until rst.
- Undefined: seq_err is driven constant 0 and no checker logic is built.

Decomposition:
- Package ctrl_pkg holds:
  - FSM state enum.
  - CNT_DONE (all-ones of CNT_W).
  - Derived constants WB_STEP=MAT_SIZE+2 and DRAIN_STEP=MAT_SIZE+1.
- One natural sub-module: ctrl_valid_delay, a parameterised RD_LAT-deep shift register with async active-high clear. It produces mac_en and is reusable for other latency-matched strobes.

Test Plan:
- Nominal run: start=1 from reset, counter 0..66 then 0xFF.
  - acc_clr one cycle.
  - rd_en high 64 cycles with rd_addr 0..63.
  - mac_en same 64 cycles shifted by RD_LAT=1.
  - out_we one pulse after count 66.
  - done=1 after end_signal.
- Stall: drop start for 3 cycles at count 20.
  - rd_en low for 3 cycles; rd_addr holds 19.
  - mac_en shows a 3-cycle bubble 1 cycle later.
  - Totals remain 64.
- Handshake: hold host_ack=1 throughout.
  - done still rises for one cycle, then clears; HALT outputs all 0.
  - With ack delayed 10 cycles, done stays high exactly until the cycle after ack.
- Reset mid-run at count 40: all outputs 0 asynchronously; after release, a fresh run behaves as the nominal run.
- RD_LAT=3 build, nominal run: mac_en lags rd_en by 3 cycles, with 64 high cycles.
- CTRL_SEQ_CHECK_EN build: force count 10 -> 12.
  - seq_err=1 next cycle and stays set through done.
  - Without the macro, seq_err stays 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and step constants for the vector-multiplier control sequence decoder.
package ctrl_pkg;

    localparam int MAT_SIZE_DEF = 64;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_WB     = 3'd3,
        ST_DONE   = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_e;

    function automatic int drain_step(input int mat);
        return mat + 1;
    endfunction

    function automatic int wb_step(input int mat);
        return mat + 2;
    endfunction

    localparam logic [CNT_W_DEF-1:0] CNT_DONE   = '1;
    localparam int                   DRAIN_STEP = drain_step(MAT_SIZE_DEF);
    localparam int                   WB_STEP    = wb_step(MAT_SIZE_DEF);

endpackage

// File: rtl/ctrl_seq_decoder_valid_delay.sv
// ctrl_valid_delay: DEPTH-cycle strobe delay line with asynchronous active-high clear.
module ctrl_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_pipe;

    // Concatenate-and-truncate keeps DEPTH=1 legal without a separate generate branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= DEPTH'({r_pipe, i_valid});
        end
    end

    assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/ctrl_seq_decoder.sv
// Step-count decoder driving operand reads, MAC enable, accumulator clear, write-back and done.
// Optional sequence checker built only when CTRL_SEQ_CHECK_EN is defined; otherwise seq_err is tied 0.
//   state  | meaning
//   IDLE   | waiting for start with count 0
//   STREAM | issuing operand reads for counts 1..MAT_SIZE
//   DRAIN  | count MAT_SIZE+1, waiting for start to move on
//   WB     | write-back pulse at MAT_SIZE+2, waiting for end flag
//   DONE   | done held until host ack
//   HALT   | quiescent until reset
module ctrl_seq_decoder
    import ctrl_pkg::*;
#(
    parameter int MAT_SIZE = MAT_SIZE_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = $clog2(MAT_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  state_count,
    input  logic              end_signal,
    input  logic              host_ack,
    output logic              acc_clr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              mac_en,
    output logic              out_we,
    output logic              done,
    output logic              seq_err
);

    localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(MAT_SIZE);
    localparam logic [CNT_W-1:0] L_DRAIN = CNT_W'(drain_step(MAT_SIZE));
    localparam logic [CNT_W-1:0] L_WB    = CNT_W'(wb_step(MAT_SIZE));

    ctrl_state_e r_state;
    logic        r_end_q;
    logic        r_wb_fired;
    logic        w_end_rise;
    logic        w_stream_cnt;

    assign w_end_rise   = end_signal & ~r_end_q;
    assign w_stream_cnt = (state_count != '0) && (state_count <= L_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_end_q    <= 1'b0;
            r_wb_fired <= 1'b0;
            acc_clr    <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            out_we     <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_end_q <= end_signal;
            acc_clr <= 1'b0;
            rd_en   <= 1'b0;
            out_we  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && state_count == '0) begin
                        acc_clr <= 1'b1;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (start && w_stream_cnt) begin
                        rd_en   <= 1'b1;
                        rd_addr <= ADDR_W'(state_count - CNT_W'(1));
                        if (state_count == L_LAST) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (start && state_count == L_DRAIN) r_state <= ST_WB;
                end
                ST_WB: begin
                    if (start && state_count == L_WB && !r_wb_fired) begin
                        out_we     <= 1'b1;
                        r_wb_fired <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // done is registered, so an ack arriving with its rising edge is not seen here.
                    if (host_ack && done) begin
                        done    <= 1'b0;
                        rd_addr <= '0;
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    done    <= 1'b0;
                    rd_addr <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_end_rise && (r_state inside {ST_STREAM, ST_DRAIN, ST_WB})) begin
                done    <= 1'b1;
                r_state <= ST_DONE;
            end
        end
    end

    ctrl_valid_delay #(.DEPTH(RD_LAT)) u_mac_dly (
        .clk     (clk),
        .rst     (rst),
        .i_valid (rd_en),
        .o_valid (mac_en)
    );

`ifdef CTRL_SEQ_CHECK_EN
    localparam logic [CNT_W-1:0] L_CNT_DONE = '1;

    logic [CNT_W-1:0] r_cnt_q;
    logic             w_step_ok;

    assign w_step_ok = (state_count == r_cnt_q)
                    || (state_count == r_cnt_q + CNT_W'(1))
                    || (r_cnt_q == L_WB && state_count == L_CNT_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= '0;
            seq_err <= 1'b0;
        end else begin
            r_cnt_q <= state_count;
            if (start && !(r_state inside {ST_IDLE, ST_HALT}) && !w_step_ok) seq_err <= 1'b1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// Randomised bench for ctrl_seq_decoder against a rule-level reference model.
module tb_ctrl_seq_decoder;
    import ctrl_pkg::*;

    parameter int RD_LAT = 1;
    localparam int          MS       = MAT_SIZE_DEF;
    localparam logic [7:0]  LAST_CNT = 8'(WB_STEP);

    logic       clk, rst, start, end_signal, host_ack;
    logic [7:0] state_count;
    logic       acc_clr, rd_en, mac_en, out_we, done, seq_err;
    logic [5:0] rd_addr;

    ctrl_seq_decoder #(.MAT_SIZE(MS), .CNT_W(8), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_count (state_count),
        .end_signal  (end_signal),
        .host_ack    (host_ack),
        .acc_clr     (acc_clr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .mac_en      (mac_en),
        .out_we      (out_we),
        .done        (done),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state
    bit         m_started, m_past_stream, m_done_seen, m_halted, m_we_fired, m_prev_end, m_err;
    logic [7:0] m_prev_cnt;
    bit         exp_acc, exp_rd, exp_mac, exp_we, exp_done, exp_err;
    logic [5:0] exp_addr;
    bit         rd_q[$];

    // bench-side step counter
    logic [7:0] b_cnt;
    bit         b_end, jump_en;
    int         n_rd, n_mac, n_acc, n_we, n_done_rise, n_done_hi;
    bit         prev_done_obs;

    task automatic model_reset();
        m_started = 0; m_past_stream = 0; m_done_seen = 0; m_halted = 0;
        m_we_fired = 0; m_prev_end = 0; m_err = 0; m_prev_cnt = 8'd0;
        exp_acc = 0; exp_rd = 0; exp_mac = 0; exp_we = 0; exp_done = 0; exp_err = 0;
        exp_addr = 6'd0;
        rd_q = {};
        for (int i = 0; i < RD_LAT; i++) rd_q.push_back(1'b0);
    endtask

    task automatic model_step(input bit s, input logic [7:0] c, input bit e, input bit a);
        bit rise;
        bit active;
        rise   = e && !m_prev_end;
        active = m_started && !m_halted;
`ifdef CTRL_SEQ_CHECK_EN
        if (active && s && c != m_prev_cnt && c != 8'(m_prev_cnt + 8'd1)
            && !(m_prev_cnt == LAST_CNT && c == 8'hFF)) m_err = 1;
`endif
        exp_acc = 0; exp_rd = 0; exp_we = 0;
        if (m_halted) begin
            exp_done = 0;
            exp_addr = 6'd0;
        end else if (!m_started) begin
            if (s && c == 8'd0) begin
                exp_acc   = 1;
                m_started = 1;
            end
        end else if (!m_done_seen) begin
            if (s && !m_past_stream && c >= 8'd1 && c <= 8'(MS)) begin
                exp_rd   = 1;
                exp_addr = 6'(c - 8'd1);
                if (c == 8'(MS)) m_past_stream = 1;
            end
            if (s && m_past_stream && c == LAST_CNT && !m_we_fired) begin
                exp_we     = 1;
                m_we_fired = 1;
            end
            if (rise) begin
                exp_done    = 1;
                m_done_seen = 1;
            end
        end else if (a && exp_done) begin
            exp_done = 0;
            exp_addr = 6'd0;
            m_halted = 1;
        end
        if (!active) exp_err = m_err;
        exp_err    = m_err;
        m_prev_end = e;
        m_prev_cnt = c;
        rd_q.push_back(exp_rd);
        exp_mac = rd_q.pop_front();
    endtask

    task automatic step(input bit s, input bit a);
        start = s; state_count = b_cnt; end_signal = b_end; host_ack = a;
        model_step(s, b_cnt, b_end, a);
        @(posedge clk);
        #1;
        check("acc_clr", acc_clr, exp_acc);
        check("rd_en",   rd_en,   exp_rd);
        check("rd_addr", rd_addr, exp_addr);
        check("mac_en",  mac_en,  exp_mac);
        check("out_we",  out_we,  exp_we);
        check("done",    done,    exp_done);
        check("seq_err", seq_err, exp_err);
        if (rd_en)   n_rd++;
        if (mac_en)  n_mac++;
        if (acc_clr) n_acc++;
        if (out_we)  n_we++;
        if (done) n_done_hi++;
        if (done && !prev_done_obs) n_done_rise++;
        prev_done_obs = done;
        if (s) begin
            if (b_cnt == 8'hFF)               b_cnt = 8'hFF;
            else if (b_cnt == LAST_CNT)       b_cnt = 8'hFF;
            else if (jump_en && b_cnt == 8'd10) b_cnt = 8'd12;
            else                              b_cnt = b_cnt + 8'd1;
        end
        b_end = (b_cnt == 8'hFF);
    endtask

    task automatic do_reset();
        rst = 1; start = 0; host_ack = 0; end_signal = 0; state_count = 8'd0;
        b_cnt = 8'd0; b_end = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("reset_acc_clr", acc_clr, 0);
        check("reset_rd_en",   rd_en,   0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_mac_en",  mac_en,  0);
        check("reset_out_we",  out_we,  0);
        check("reset_done",    done,    0);
        check("reset_seq_err", seq_err, 0);
    endtask

    task automatic mid_reset();
        #3;
        rst = 1;
        #1;
        check("midrst_acc_clr", acc_clr, 0);
        check("midrst_rd_en",   rd_en,   0);
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_mac_en",  mac_en,  0);
        check("midrst_done",    done,    0);
        do_reset();
    endtask

    // smode: 0 always run, 1 three-cycle stall after count 20, 2 random stalls
    // amode: 0 ack always high, 1 ack after ack_delay done cycles, 2 random ack
    task automatic run_one(input int smode, input int amode, input int ack_delay,
                           input bit jump, input int rst_at, input bit tot_chk);
        int cyc;
        int stall_cnt;
        bit s, a;
        cyc = 0; stall_cnt = 0;
        n_rd = 0; n_mac = 0; n_acc = 0; n_we = 0; n_done_rise = 0; n_done_hi = 0;
        prev_done_obs = 0;
        jump_en = jump;
        while (!m_halted && cyc < 400) begin
            if (rst_at >= 0 && b_cnt == 8'(rst_at)) begin
                mid_reset();
                return;
            end
            s = 1;
            if (smode == 1 && b_cnt == 8'd21 && stall_cnt < 3) begin
                s = 0;
                stall_cnt++;
            end else if (smode == 2) begin
                s = ($urandom_range(0, 3) != 0);
            end
            case (amode)
                0:       a = 1;
                1:       a = (n_done_hi >= ack_delay);
                default: a = ($urandom_range(0, 1) == 1);
            endcase
            step(s, a);
            if (acc_clr) check("acc_cycle", cyc, 0);
            if (rd_en && n_rd == 1) check("first_addr", rd_addr, 0);
            if (tot_chk && rd_en && n_rd == MS) check("last_addr", rd_addr, 63);
            if (smode == 1 && !s) begin
                check("stall_addr", rd_addr, 19);
                check("stall_rd_en", rd_en, 0);
            end
            cyc++;
        end
        if (!m_halted) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: got running after %0d cycles expected HALT", cyc);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        if (tot_chk) begin
            check("total_rd_en",  n_rd,  64);
            check("total_mac_en", n_mac, 64);
            check("total_acc",    n_acc, 1);
            check("total_we",     n_we,  1);
            check("total_done",   n_done_rise, 1);
        end
        if (amode == 0) check("done_width_ack_held", n_done_hi, 1);
        if (amode == 1) check("done_width_ack_delay", n_done_hi, 32'(ack_delay));
    endtask

    initial begin
        rst = 1; start = 0; host_ack = 0; end_signal = 0; state_count = 8'd0;
        do_reset();
        run_one(0, 1, 10, 0, -1, 1);
        do_reset();
        run_one(1, 0, 0, 0, -1, 1);
        do_reset();
        run_one(0, 0, 0, 0, 40, 0);
        run_one(0, 1, 4, 0, -1, 1);
        for (int r = 0; r < 4; r++) begin
            do_reset();
            run_one(2, 2, 0, 0, -1, 1);
        end
        do_reset();
        run_one(0, 0, 0, 1, -1, 0);
`ifdef CTRL_SEQ_CHECK_EN
        check("seq_err_after_jump", seq_err, 1);
`else
        check("seq_err_after_jump", seq_err, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
